// File: rtl/thumb_fetch_queue_if.sv
// Handshake bundle between the instruction fetch path and the Thumb fetch queue.
//   master : fetch unit / consumer side (drives fetch beats, flush and inst_ready)
//   slave  : queue side (drives fetch_ready, inst, inst_is32, inst_valid, count)
// Signals:
//   fetch_data  [16*FETCH_HW] fetched halfwords, [15:0] oldest in program order
//   fetch_valid / fetch_ready beat handshake
//   flush, flush_skip         redirect; flush_skip drops first halfword of next beat
//   inst, inst_is32           head instruction and its size
//   inst_valid / inst_ready   instruction handshake
//   count                     halfwords currently held
interface thumb_fetch_queue_if #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned FETCH_HW = 2
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [16*FETCH_HW-1:0] fetch_data;
  logic                   fetch_valid;
  logic                   fetch_ready;
  logic                   flush;
  logic                   flush_skip;
  logic [31:0]            inst;
  logic                   inst_is32;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [CntW-1:0]        count;

  modport master (
    output fetch_data, fetch_valid, flush, flush_skip, inst_ready,
    input  fetch_ready, inst, inst_is32, inst_valid, count
  );

  modport slave (
    input  fetch_data, fetch_valid, flush, flush_skip, inst_ready,
    output fetch_ready, inst, inst_is32, inst_valid, count
  );
endinterface

// File: rtl/thumb_fetch_queue.sv
// Thumb/Thumb-2 fetch queue: buffers fetched halfwords in a circular buffer and presents
// the head instruction (16- or 32-bit) to pre-decode.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  thumb_fetch_queue_if.slave (fetch beat in, instruction out, flush, count)
module thumb_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned FETCH_HW = 2
) (
  input logic                clk,
  input logic                rst,
  thumb_fetch_queue_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Storage is never reset; only pointers/count define which slots are live.
  logic [15:0]     r_mem [DEPTH];
  logic [PtrW-1:0] r_rptr;
  logic [PtrW-1:0] r_wptr;
  logic [CntW-1:0] r_count;
  logic            r_skip;

  logic [15:0]     w_hw0;
  logic [15:0]     w_hw1;
  logic            w_is32;
  logic            w_inst_valid;
  logic            w_fetch_ready;
  logic            w_push;
  logic            w_pop;
  logic [CntW-1:0] w_free;
  logic [1:0]      w_push_n;
  logic [1:0]      w_pop_n;
  logic            w_lane_we   [FETCH_HW];
  logic [PtrW-1:0] w_lane_addr [FETCH_HW];

  assign w_free = CntW'(DEPTH) - r_count;
  // Free space is judged on the current count only, so a same-cycle pop never opens the gate.
  assign w_fetch_ready = !rst && !bus.flush && (w_free >= CntW'(FETCH_HW));
  assign w_push        = bus.fetch_valid && w_fetch_ready;

  // A pending skip drops the oldest halfword of the beat.
  assign w_push_n = !w_push ? 2'd0 : (r_skip ? 2'(FETCH_HW - 1) : 2'(FETCH_HW));

  assign w_hw0  = r_mem[r_rptr];
  assign w_hw1  = r_mem[r_rptr + PtrW'(1)];
  // 32-bit Thumb-2 prefixes: 11101, 11110, 11111.
  assign w_is32 = (w_hw0[15:13] == 3'b111) && (w_hw0[12:11] != 2'b00);

  assign w_inst_valid = !bus.flush && (w_is32 ? (r_count >= CntW'(2)) : (r_count >= CntW'(1)));
  assign w_pop        = w_inst_valid && bus.inst_ready;
  assign w_pop_n      = !w_pop ? 2'd0 : (w_is32 ? 2'd2 : 2'd1);

  // Lane i lands at wptr + i, shifted down by one when lane 0 is being skipped.
  always_comb begin
    for (int i = 0; i < FETCH_HW; i++) begin
      w_lane_we[i]   = w_push && !(r_skip && (i == 0));
      w_lane_addr[i] = r_wptr + PtrW'(i) - PtrW'(r_skip);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_HW; i++) begin
      if (w_lane_we[i]) begin
        r_mem[w_lane_addr[i]] <= bus.fetch_data[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_skip  <= 1'b0;
    end else if (bus.flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_skip  <= bus.flush_skip;
    end else begin
      r_rptr  <= r_rptr + PtrW'(w_pop_n);
      r_wptr  <= r_wptr + PtrW'(w_push_n);
      r_count <= r_count + CntW'(w_push_n) - CntW'(w_pop_n);
      if (w_push) begin
        r_skip <= 1'b0;
      end
    end
  end

  assign bus.fetch_ready = w_fetch_ready;
  assign bus.inst        = w_is32 ? {w_hw0, w_hw1} : {16'h0000, w_hw0};
  assign bus.inst_is32   = w_is32;
  assign bus.inst_valid  = w_inst_valid;
  assign bus.count       = r_count;
endmodule
